// File: rtl/arith_issue_queue_v2_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arith_issue_queue_v2_if : dispatch / wakeup / recall / issue bundle          |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface arith_issue_queue_v2_if #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int ISSUE_W   = 2,
  parameter int WAKE_W    = 2,
  parameter int PREG_W    = 6,
  parameter int AL_W      = 5,
  parameter int PAYLOAD_W = 96
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                           ext_stall;
  logic [DISP_W-1:0]              disp_valid;
  logic [DISP_W*PREG_W-1:0]       disp_src1;
  logic [DISP_W*PREG_W-1:0]       disp_src2;
  logic [DISP_W-1:0]              disp_use1;
  logic [DISP_W-1:0]              disp_use2;
  logic [DISP_W*AL_W-1:0]         disp_al_idx;
  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload;
  logic                           disp_ready;
  logic [2**PREG_W-1:0]           bbt;
  logic [WAKE_W-1:0]              wake_valid;
  logic [WAKE_W*PREG_W-1:0]       wake_tag;
  logic [AL_W-1:0]                al_head;
  logic                           recall;
  logic [AL_W-1:0]                recall_idx;
  logic [ISSUE_W-1:0]             iss_valid;
  logic [ISSUE_W-1:0]             iss_ready;
  logic [ISSUE_W*PREG_W-1:0]      iss_src1;
  logic [ISSUE_W*PREG_W-1:0]      iss_src2;
  logic [ISSUE_W*AL_W-1:0]        iss_al_idx;
  logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload;
  logic [OCC_W-1:0]               occupancy;

  modport master (
    output ext_stall, disp_valid, disp_src1, disp_src2, disp_use1, disp_use2,
           disp_al_idx, disp_payload, bbt, wake_valid, wake_tag, al_head,
           recall, recall_idx, iss_ready,
    input  disp_ready, iss_valid, iss_src1, iss_src2, iss_al_idx, iss_payload,
           occupancy
  );

  modport slave (
    input  ext_stall, disp_valid, disp_src1, disp_src2, disp_use1, disp_use2,
           disp_al_idx, disp_payload, bbt, wake_valid, wake_tag, al_head,
           recall, recall_idx, iss_ready,
    output disp_ready, iss_valid, iss_src1, iss_src2, iss_al_idx, iss_payload,
           occupancy
  );
endinterface
`default_nettype wire

// File: rtl/arith_issue_queue_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arith_issue_queue_v2 : age-ordered integer issue queue with wakeup/recall    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module arith_issue_queue_v2 #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int ISSUE_W   = 2,
  parameter int WAKE_W    = 2,
  parameter int PREG_W    = 6,
  parameter int AL_W      = 5,
  parameter int PAYLOAD_W = 96
) (
  input  logic                  clk,
  input  logic                  reset_n,
  arith_issue_queue_v2_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [PREG_W-1:0]    src1_q [DEPTH];
  logic [PREG_W-1:0]    src2_q [DEPTH];
  logic [AL_W-1:0]      al_q   [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];

  logic [AL_W-1:0]      age   [DEPTH];
  logic [OCC_W-1:0]     rank  [DEPTH];
  logic [OCC_W-1:0]     frank [DEPTH];
  logic [DEPTH-1:0]     ent_rdy, fire, wr_en, wrdy1, wrdy2;
  logic [PREG_W-1:0]    wsrc1 [DEPTH];
  logic [PREG_W-1:0]    wsrc2 [DEPTH];
  logic [AL_W-1:0]      wal   [DEPTH];
  logic [PAYLOAD_W-1:0] wpay  [DEPTH];
  logic [AL_W-1:0]      rcl_age;
  logic                 issue_en, disp_rdy;

  function automatic logic woke(input logic [PREG_W-1:0]        tag,
                                input logic [WAKE_W-1:0]        wv,
                                input logic [WAKE_W*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_W; w++)
      if (wv[w] && wt[w*PREG_W +: PREG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  // rank = number of older ready entries; frank = number of free slots below
  always_comb begin
    issue_en = !bus.ext_stall && !bus.recall;
    disp_rdy = issue_en && (int'(occ_q) + DISP_W <= DEPTH);
    rcl_age  = bus.recall_idx - bus.al_head;
    for (int i = 0; i < DEPTH; i++) begin
      age[i]     = al_q[i] - bus.al_head;
      ent_rdy[i] = valid_q[i] & rdy1_q[i] & rdy2_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      rank[i]  = '0;
      frank[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ent_rdy[j] && age[j] < age[i]) rank[i] = rank[i] + OCC_W'(1);
        if (j < i && !valid_q[j]) frank[i] = frank[i] + OCC_W'(1);
      end
    end
  end

  always_comb begin
    bus.iss_valid   = '0;
    bus.iss_src1    = '0;
    bus.iss_src2    = '0;
    bus.iss_al_idx  = '0;
    bus.iss_payload = '0;
    fire            = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_en && ent_rdy[i] && rank[i] == OCC_W'(k)) begin
          bus.iss_valid[k]                        = 1'b1;
          bus.iss_src1[k*PREG_W +: PREG_W]        = src1_q[i];
          bus.iss_src2[k*PREG_W +: PREG_W]        = src2_q[i];
          bus.iss_al_idx[k*AL_W +: AL_W]          = al_q[i];
          bus.iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
          fire[i]                                 = fire[i] | bus.iss_ready[k];
        end
      end
    end
  end

  always_comb begin
    wr_en = '0;
    wrdy1 = '0;
    wrdy2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wsrc1[i] = '0;
      wsrc2[i] = '0;
      wal[i]   = '0;
      wpay[i]  = '0;
      for (int j = 0; j < DISP_W; j++) begin
        if (disp_rdy && bus.disp_valid[j] && !valid_q[i] && frank[i] == OCC_W'(j)) begin
          wr_en[i] = 1'b1;
          wsrc1[i] = bus.disp_src1[j*PREG_W +: PREG_W];
          wsrc2[i] = bus.disp_src2[j*PREG_W +: PREG_W];
          wal[i]   = bus.disp_al_idx[j*AL_W +: AL_W];
          wpay[i]  = bus.disp_payload[j*PAYLOAD_W +: PAYLOAD_W];
          wrdy1[i] = !bus.disp_use1[j] || !bus.bbt[wsrc1[i]] ||
                     woke(wsrc1[i], bus.wake_valid, bus.wake_tag);
          wrdy2[i] = !bus.disp_use2[j] || !bus.bbt[wsrc2[i]] ||
                     woke(wsrc2[i], bus.wake_valid, bus.wake_tag);
        end
      end
    end
  end

  // recall wins over issue and dispatch; wakeups are captured regardless
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    occ_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_d[i] = rdy1_q[i] | woke(src1_q[i], bus.wake_valid, bus.wake_tag);
      rdy2_d[i] = rdy2_q[i] | woke(src2_q[i], bus.wake_valid, bus.wake_tag);
      if (bus.recall) begin
        if (age[i] > rcl_age) valid_d[i] = 1'b0;
      end else begin
        if (fire[i]) valid_d[i] = 1'b0;
        if (wr_en[i]) begin
          valid_d[i] = 1'b1;
          rdy1_d[i]  = wrdy1[i];
          rdy2_d[i]  = wrdy2[i];
        end
      end
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        src1_q[i] <= wsrc1[i];
        src2_q[i] <= wsrc2[i];
        al_q[i]   <= wal[i];
        pay_q[i]  <= wpay[i];
      end
    end
  end

  assign bus.disp_ready = disp_rdy;
  assign bus.occupancy  = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_issue_queue_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arith_issue_queue_v2 : directed + random bench against an age-list model  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_arith_issue_queue_v2;
  localparam int DEPTH = 8, DISP_W = 2, ISSUE_W = 2, WAKE_W = 2;
  localparam int PREG_W = 6, AL_W = 5, PAYLOAD_W = 96;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  arith_issue_queue_v2_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .WAKE_W(WAKE_W),
                            .PREG_W(PREG_W), .AL_W(AL_W), .PAYLOAD_W(PAYLOAD_W)) qi ();

  arith_issue_queue_v2 #(.DEPTH(DEPTH), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .WAKE_W(WAKE_W),
                         .PREG_W(PREG_W), .AL_W(AL_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (qi)
  );

  typedef struct {
    logic [5:0]  s1, s2;
    logic        r1, r2;
    logic [4:0]  al;
    logic [95:0] pay;
  } ent_t;

  ent_t               mq[$];
  int                 n_tot = 0, n_bad = 0;
  int                 exp_idx [ISSUE_W];
  logic [ISSUE_W-1:0] exp_v;
  logic               exp_drdy;
  logic [4:0]         tail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] age_of(input logic [4:0] a);
    return a - qi.al_head;
  endfunction

  function automatic logic woke(input logic [5:0] t);
    for (int w = 0; w < WAKE_W; w++)
      if (qi.wake_valid[w] && qi.wake_tag[w*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    qi.ext_stall    = 1'b0;
    qi.recall       = 1'b0;
    qi.recall_idx   = '0;
    qi.disp_valid   = '0;
    qi.disp_src1    = '0;
    qi.disp_src2    = '0;
    qi.disp_use1    = '0;
    qi.disp_use2    = '0;
    qi.disp_al_idx  = '0;
    qi.disp_payload = '0;
    qi.bbt          = '0;
    qi.wake_valid   = '0;
    qi.wake_tag     = '0;
    qi.iss_ready    = '1;
  endtask

  task automatic put(input int j, input logic [4:0] al, input logic [5:0] s1, input logic u1,
                     input logic [5:0] s2, input logic u2);
    qi.disp_valid[j]             = 1'b1;
    qi.disp_src1[j*6 +: 6]       = s1;
    qi.disp_use1[j]              = u1;
    qi.disp_src2[j*6 +: 6]       = s2;
    qi.disp_use2[j]              = u2;
    qi.disp_al_idx[j*5 +: 5]     = al;
    qi.disp_payload[j*96 +: 96]  = {$urandom, $urandom, $urandom};
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int del[$];
    @(negedge clk);
    exp_drdy = !qi.ext_stall && !qi.recall && (DEPTH - mq.size() >= DISP_W);
    exp_v    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      int best;
      best = -1;
      exp_idx[k] = -1;
      if (!qi.ext_stall && !qi.recall) begin
        for (int i = 0; i < mq.size(); i++) begin
          bit taken;
          taken = 1'b0;
          for (int m = 0; m < k; m++) if (exp_idx[m] == i) taken = 1'b1;
          if (!taken && mq[i].r1 && mq[i].r2 &&
              (best < 0 || age_of(mq[i].al) < age_of(mq[best].al))) best = i;
        end
      end
      exp_idx[k] = best;
      exp_v[k]   = (best >= 0);
    end
    chk("occupancy", 128'(qi.occupancy), 128'(mq.size()));
    chk("disp_ready", 128'(qi.disp_ready), 128'(exp_drdy));
    chk("iss_valid", 128'(qi.iss_valid), 128'(exp_v));
    for (int k = 0; k < ISSUE_W; k++) begin
      if (exp_v[k] && qi.iss_valid[k]) begin
        chk("iss_al_idx", 128'(qi.iss_al_idx[k*5 +: 5]), 128'(mq[exp_idx[k]].al));
        chk("iss_src1", 128'(qi.iss_src1[k*6 +: 6]), 128'(mq[exp_idx[k]].s1));
        chk("iss_src2", 128'(qi.iss_src2[k*6 +: 6]), 128'(mq[exp_idx[k]].s2));
        chk("iss_payload", 128'(qi.iss_payload[k*96 +: 96]), 128'(mq[exp_idx[k]].pay));
      end
    end
    @(posedge clk);
    if (qi.recall) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (age_of(mq[i].al) > age_of(qi.recall_idx)) mq.delete(i);
    end else if (!qi.ext_stall) begin
      for (int k = 0; k < ISSUE_W; k++)
        if (exp_v[k] && qi.iss_ready[k]) del.push_back(exp_idx[k]);
      del.rsort();
      foreach (del[d]) mq.delete(del[d]);
    end
    foreach (mq[i]) begin
      if (woke(mq[i].s1)) mq[i].r1 = 1'b1;
      if (woke(mq[i].s2)) mq[i].r2 = 1'b1;
    end
    if (exp_drdy) begin
      for (int j = 0; j < DISP_W; j++) begin
        if (qi.disp_valid[j]) begin
          ent_t e;
          e.s1  = qi.disp_src1[j*6 +: 6];
          e.s2  = qi.disp_src2[j*6 +: 6];
          e.r1  = !qi.disp_use1[j] || !qi.bbt[e.s1] || woke(e.s1);
          e.r2  = !qi.disp_use2[j] || !qi.bbt[e.s2] || woke(e.s2);
          e.al  = qi.disp_al_idx[j*5 +: 5];
          e.pay = qi.disp_payload[j*96 +: 96];
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  initial begin
    idle();
    qi.al_head = '0;
    tail       = '0;
    #12 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_disp_ready", 128'(qi.disp_ready), 128'(1));
    chk("rst_iss_valid", 128'(qi.iss_valid), 128'(0));
    chk("rst_occupancy", 128'(qi.occupancy), 128'(0));
    @(posedge clk);
    #1;

    // two ready ops, oldest on channel 0 the next cycle
    idle(); put(0, 5'd0, 6'd1, 1'b1, 6'd2, 1'b1); put(1, 5'd1, 6'd3, 1'b1, 6'd4, 1'b0);
    cycle();
    idle(); cycle();
    chk("two_ops_issue", 128'(qi.occupancy), 128'(0));

    // busy source woken in the dispatch cycle
    idle(); qi.bbt[5] = 1'b1; put(0, 5'd2, 6'd5, 1'b1, 6'd0, 1'b0);
    qi.wake_valid = 2'b01; qi.wake_tag[5:0] = 6'd5;
    cycle();
    idle(); qi.bbt[5] = 1'b1; cycle();
    idle(); cycle();

    // active-list wrap: head 30, ops at 31, 0, 1
    qi.al_head = 5'd30;
    idle(); qi.iss_ready = '0; put(0, 5'd31, 6'd1, 1'b1, 6'd1, 1'b1); put(1, 5'd0, 6'd2, 1'b0, 6'd2, 1'b0);
    cycle();
    idle(); qi.iss_ready = '0; put(0, 5'd1, 6'd3, 1'b1, 6'd3, 1'b0);
    cycle();
    for (int c = 0; c < 3; c++) begin idle(); cycle(); end

    // consumer back-pressure, then release
    idle(); put(0, 5'd2, 6'd1, 1'b0, 6'd1, 1'b0); put(1, 5'd3, 6'd1, 1'b0, 6'd1, 1'b0);
    cycle();
    for (int c = 0; c < 3; c++) begin idle(); qi.iss_ready = 2'b01; cycle(); end
    for (int c = 0; c < 2; c++) begin idle(); cycle(); end

    // recall with dispatch active: entries 3..7 blocked, recall at 5
    qi.al_head = 5'd3;
    for (int c = 0; c < 3; c++) begin
      idle(); qi.bbt[10] = 1'b1;
      put(0, 5'(3 + 2*c), 6'd10, 1'b1, 6'd0, 1'b0);
      if (c < 2) put(1, 5'(4 + 2*c), 6'd10, 1'b1, 6'd0, 1'b0);
      cycle();
    end
    idle(); qi.bbt[10] = 1'b1; qi.recall = 1'b1; qi.recall_idx = 5'd5;
    put(0, 5'd8, 6'd10, 1'b1, 6'd0, 1'b0); put(1, 5'd9, 6'd10, 1'b1, 6'd0, 1'b0);
    cycle();
    chk("recall_occupancy", 128'(qi.occupancy), 128'(3));

    // fill with blocked ops until the queue refuses a full group
    for (int c = 0; c < 3; c++) begin
      idle(); qi.bbt[10] = 1'b1;
      put(0, 5'(6 + 2*c), 6'd10, 1'b1, 6'd0, 1'b0); put(1, 5'(7 + 2*c), 6'd10, 1'b1, 6'd0, 1'b0);
      cycle();
    end
    chk("full_occupancy", 128'(qi.occupancy), 128'(7));
    idle(); qi.wake_valid = 2'b10; qi.wake_tag[11:6] = 6'd10; cycle();
    for (int c = 0; c < 5; c++) begin idle(); cycle(); end

    // asynchronous reset with live entries
    idle(); qi.bbt[10] = 1'b1;
    put(0, 5'd20, 6'd10, 1'b1, 6'd0, 1'b0); put(1, 5'd21, 6'd10, 1'b1, 6'd0, 1'b0);
    cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_occupancy", 128'(qi.occupancy), 128'(0));
    chk("async_rst_iss_valid", 128'(qi.iss_valid), 128'(0));
    mq.delete();
    idle();
    qi.al_head = '0;
    tail       = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      int          span, minage, adv;
      logic [4:0]  tmp;
      idle();
      span   = int'(5'(tail - qi.al_head));
      minage = span;
      foreach (mq[i]) if (int'(age_of(mq[i].al)) < minage) minage = int'(age_of(mq[i].al));
      adv = $urandom_range(0, 2);
      if (adv > minage) adv = minage;
      qi.al_head = qi.al_head + 5'(adv);
      span       = span - adv;
      qi.ext_stall  = ($urandom % 8 == 0);
      qi.bbt        = {$urandom, $urandom};
      qi.wake_valid = 2'($urandom);
      qi.wake_tag   = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      qi.iss_ready  = 2'($urandom);
      tmp = tail;
      for (int j = 0; j < DISP_W; j++) begin
        if ($urandom % 4 != 0 && span < 28) begin
          put(j, tmp, 6'($urandom_range(0, 15)), 1'($urandom), 6'($urandom_range(0, 15)), 1'($urandom));
          tmp = tmp + 5'd1;
        end
      end
      if (span != 0 && $urandom % 16 == 0) begin
        qi.recall     = 1'b1;
        qi.recall_idx = qi.al_head + 5'($urandom_range(0, span - 1));
      end
      cycle();
      if (qi.recall) tail = qi.recall_idx + 5'd1;
      else if (exp_drdy) tail = tmp;
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
